// File: rtl/lq_agen_lo_dirq.sv
// Load-queue agen low-order consumer: buffers agen results, computes alignment/crossing
// flags and issues one or two L1 directory beats per access. Optional macro: LQ_AGEN_LO_PERF_EN.
module lq_agen_lo_dirq #(
  parameter int QDEPTH = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex2_vld,
  output logic              ex2_rdy,
  input  logic [0:11]       ex2_sum,
  input  logic [0:5]        ex2_sum_arr,
  input  logic              ex2_dir_ig_57_b,
  input  logic [0:2]        ex2_size,
  input  logic [0:1]        ex2_tid,
  input  logic [0:3]        flush,
  output logic              dir_vld,
  input  logic              dir_rdy,
  output logic [0:5]        dir_cclass,
  output logic [0:11]       dir_sum,
  output logic [0:1]        dir_tid,
  output logic              dir_second,
  output logic              dir_misalign,
  output logic              dir_line_cross,
  output logic              dir_page_cross,
  input  logic              perf_clr,
  output logic [0:PERF_W-1] perf_split_cnt
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int IW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef struct packed {
    logic [11:0] sum;
    logic [5:0]  arr;
    logic        ig57_b;
    logic [1:0]  tid;
    logic        misalign;
    logic        line_cross;
    logic        page_cross;
  } entry_t;

  typedef enum logic {ST_FIRST = 1'b0, ST_SECOND = 1'b1} state_t;

  entry_t        ent_q [QDEPTH];
  entry_t        ent_d [QDEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;

  logic [11:0]   sum_le_s;
  logic [4:0]    mask_s;
  logic [6:0]    line_end_s;
  logic [12:0]   page_end_s;
  entry_t        new_ent_s;
  logic          enq_s;
  logic          head_vld_s;
  logic          head_flush_s;
  logic          hs_s;
  logic          pop_s;
  logic [5:0]    nline_s;
  logic [CW-1:0] wr_idx_s;

  // Size decode and per-request flag computation for the incoming request.
  always_comb begin
    sum_le_s = ex2_sum;
    case (ex2_size)
      3'd0:    mask_s = 5'd0;
      3'd1:    mask_s = 5'd1;
      3'd2:    mask_s = 5'd3;
      3'd3:    mask_s = 5'd7;
      3'd4:    mask_s = 5'd15;
      3'd5:    mask_s = 5'd31;
      default: mask_s = 5'd0;
    endcase
    line_end_s           = {1'b0, sum_le_s[5:0]} + {2'b00, mask_s};
    page_end_s           = {1'b0, sum_le_s} + {8'd0, mask_s};
    new_ent_s.sum        = sum_le_s;
    new_ent_s.arr        = ex2_sum_arr;
    new_ent_s.ig57_b     = ex2_dir_ig_57_b;
    new_ent_s.tid        = ex2_tid;
    new_ent_s.misalign   = |(sum_le_s[5:0] & {1'b0, mask_s});
    new_ent_s.line_cross = line_end_s[6];
    new_ent_s.page_cross = page_end_s[12];
  end

  assign ex2_rdy      = (cnt_q < CW'(QDEPTH));
  assign enq_s        = ex2_vld & ex2_rdy & ~flush[ex2_tid];
  assign head_vld_s   = (cnt_q != {CW{1'b0}});
  assign head_flush_s = head_vld_s & flush[ent_q[0].tid];
  assign dir_vld      = head_vld_s & ~head_flush_s;
  assign hs_s         = dir_vld & dir_rdy;
  assign nline_s      = ent_q[0].sum[11:6] + 6'd1;

  // Beat sequencing: next state, pop decision and directory beat contents.
  always_comb begin
    state_d        = state_q;
    pop_s          = 1'b0;
    dir_cclass     = 6'd0;
    dir_sum        = 12'd0;
    dir_tid        = 2'd0;
    dir_second     = 1'b0;
    dir_misalign   = 1'b0;
    dir_line_cross = 1'b0;
    dir_page_cross = 1'b0;
    case (state_q)
      ST_FIRST: begin
        if (hs_s) begin
          if (ent_q[0].line_cross) begin
            state_d = ST_SECOND;
          end else begin
            pop_s = 1'b1;
          end
        end else begin
          state_d = ST_FIRST;
        end
      end
      ST_SECOND: begin
        if (hs_s) begin
          pop_s   = 1'b1;
          state_d = ST_FIRST;
        end else begin
          state_d = ST_SECOND;
        end
      end
      default: state_d = ST_FIRST;
    endcase
    // A flushed head abandons any split in progress.
    if (head_flush_s) begin
      state_d = ST_FIRST;
    end else begin
      state_d = state_d;
    end
    if (head_vld_s) begin
      dir_tid        = ent_q[0].tid;
      dir_misalign   = ent_q[0].misalign;
      dir_line_cross = ent_q[0].line_cross;
      dir_page_cross = ent_q[0].page_cross;
      if (state_q == ST_SECOND) begin
        dir_cclass = {nline_s[5:1], nline_s[0] | ~ent_q[0].ig57_b};
        dir_sum    = {nline_s, 6'd0};
        dir_second = 1'b1;
      end else begin
        dir_cclass = ent_q[0].arr;
        dir_sum    = ent_q[0].sum;
        dir_second = 1'b0;
      end
    end else begin
      dir_cclass = 6'd0;
    end
  end

  // Queue next state: drop popped head and flushed entries, compact in order, then append.
  always_comb begin
    ent_d    = ent_q;
    wr_idx_s = {CW{1'b0}};
    for (int i = 0; i < QDEPTH; i++) begin
      if ((CW'(i) < cnt_q) && !((i == 0) && pop_s) && !flush[ent_q[i].tid]) begin
        ent_d[IW'(wr_idx_s)] = ent_q[i];
        wr_idx_s             = wr_idx_s + CW'(1);
      end else begin
        wr_idx_s = wr_idx_s;
      end
    end
    if (enq_s) begin
      ent_d[IW'(wr_idx_s)] = new_ent_s;
      wr_idx_s             = wr_idx_s + CW'(1);
    end else begin
      wr_idx_s = wr_idx_s;
    end
    cnt_d = wr_idx_s;
  end

  // Queue, occupancy and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        ent_q[i] <= '0;
      end
      cnt_q   <= {CW{1'b0}};
      state_q <= ST_FIRST;
    end else begin
      ent_q   <= ent_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

`ifdef LQ_AGEN_LO_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;

  // Saturating count of completed second beats; clear wins over increment.
  always_comb begin
    if (perf_clr) begin
      perf_d = {PERF_W{1'b0}};
    end else if (hs_s && (state_q == ST_SECOND) && ~&perf_q) begin
      perf_d = perf_q + PERF_W'(1);
    end else begin
      perf_d = perf_q;
    end
  end

  // Split-access performance counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= {PERF_W{1'b0}};
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_split_cnt = perf_q;
`else
  logic unused_perf_clr_s;
  assign unused_perf_clr_s = perf_clr;
  assign perf_split_cnt    = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_lq_agen_lo_dirq.sv
// Self-checking bench for lq_agen_lo_dirq: queue-based reference model compared every cycle
// plus directed literal expectations.
module tb_lq_agen_lo_dirq;
  localparam int QDEPTH = 2;
  localparam int PERF_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic ex2_vld, ex2_rdy, ex2_dir_ig_57_b;
  logic [0:11] ex2_sum;
  logic [0:5]  ex2_sum_arr;
  logic [0:2]  ex2_size;
  logic [0:1]  ex2_tid;
  logic [0:3]  flush;
  logic dir_vld, dir_rdy, dir_second, dir_misalign, dir_line_cross, dir_page_cross;
  logic [0:5]  dir_cclass;
  logic [0:11] dir_sum;
  logic [0:1]  dir_tid;
  logic perf_clr;
  logic [0:PERF_W-1] perf_split_cnt;

  lq_agen_lo_dirq #(.QDEPTH(QDEPTH), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .ex2_vld(ex2_vld), .ex2_rdy(ex2_rdy), .ex2_sum(ex2_sum),
    .ex2_sum_arr(ex2_sum_arr), .ex2_dir_ig_57_b(ex2_dir_ig_57_b), .ex2_size(ex2_size),
    .ex2_tid(ex2_tid), .flush(flush), .dir_vld(dir_vld), .dir_rdy(dir_rdy),
    .dir_cclass(dir_cclass), .dir_sum(dir_sum), .dir_tid(dir_tid), .dir_second(dir_second),
    .dir_misalign(dir_misalign), .dir_line_cross(dir_line_cross),
    .dir_page_cross(dir_page_cross), .perf_clr(perf_clr), .perf_split_cnt(perf_split_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int sum; int arr; bit ig; int tid; int size;
  } req_t;

  req_t mq[$];
  req_t nq[$];
  req_t nr;
  bit   msec;
  int   mperf;
  bit   m_hvld, m_hfl, m_hs, m_pop, m_rdy;

  function automatic int nbytes(int sz);
    return (sz <= 5) ? (1 << sz) : 1;
  endfunction
  function automatic bit f_mis(req_t r);
    return ((r.sum % 64) % nbytes(r.size)) != 0;
  endfunction
  function automatic bit f_lc(req_t r);
    return (r.sum % 64) + nbytes(r.size) - 1 > 63;
  endfunction
  function automatic bit f_pc(req_t r);
    return r.sum + nbytes(r.size) - 1 > 4095;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      msec  = 1'b0;
      mperf = 0;
    end else begin
      m_rdy  = mq.size() < QDEPTH;
      m_hvld = mq.size() > 0;
      m_hfl  = m_hvld && flush[mq[0].tid];
      m_hs   = m_hvld && !m_hfl && dir_rdy;
      m_pop  = m_hs && (msec || !f_lc(mq[0]));
      if (perf_clr) mperf = 0;
      else if (m_hs && msec && mperf < (1 << PERF_W) - 1) mperf++;
      if (m_hfl) msec = 1'b0;
      else if (m_hs) msec = !msec && f_lc(mq[0]);
      nq.delete();
      for (int i = 0; i < mq.size(); i++) begin
        if (i == 0 && m_pop) continue;
        if (!flush[mq[i].tid]) nq.push_back(mq[i]);
      end
      if (ex2_vld && m_rdy && !flush[ex2_tid]) begin
        nr.sum = int'(ex2_sum); nr.arr = int'(ex2_sum_arr); nr.ig = ex2_dir_ig_57_b;
        nr.tid = int'(ex2_tid); nr.size = int'(ex2_size);
        nq.push_back(nr);
      end
      mq = nq;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      int n, ecc, esum, eperf;
      bit evld;
      evld = mq.size() > 0 && !flush[mq[0].tid];
`ifdef LQ_AGEN_LO_PERF_EN
      eperf = mperf;
`else
      eperf = 0;
`endif
      chk("m_vld", dir_vld, evld);
      chk("m_rdy", ex2_rdy, mq.size() < QDEPTH);
      chk("m_perf", perf_split_cnt, eperf);
      if (evld) begin
        n    = (mq[0].sum / 64 + 1) % 64;
        ecc  = msec ? ((n & 62) | ((n & 1) | (mq[0].ig ? 0 : 1))) : mq[0].arr;
        esum = msec ? n * 64 : mq[0].sum;
        chk("m_cclass", dir_cclass, ecc);
        chk("m_sum", dir_sum, esum);
        chk("m_tid", dir_tid, mq[0].tid);
        chk("m_second", dir_second, msec);
        chk("m_misalign", dir_misalign, f_mis(mq[0]));
        chk("m_line_cross", dir_line_cross, f_lc(mq[0]));
        chk("m_page_cross", dir_page_cross, f_pc(mq[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int sum, input int arr, input bit ig, input int sz, input int tid);
    ex2_sum = 12'(sum); ex2_sum_arr = 6'(arr); ex2_dir_ig_57_b = ig;
    ex2_size = 3'(sz); ex2_tid = 2'(tid); ex2_vld = 1'b1;
    @(posedge clk); #2;
    ex2_vld = 1'b0;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic pulse_clr();
    perf_clr = 1'b1;
    @(posedge clk); #2;
    perf_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex2_vld = 1'b0; ex2_sum = '0; ex2_sum_arr = '0; ex2_dir_ig_57_b = 1'b1;
    ex2_size = '0; ex2_tid = '0; flush = '0; dir_rdy = 1'b0; perf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_vld", dir_vld, 0); chk("rst_rdy", ex2_rdy, 1);
    chk("rst_sum", dir_sum, 0); chk("rst_cclass", dir_cclass, 0);
    chk("rst_perf", perf_split_cnt, 0);
    rst = 1'b0; chk_en = 1'b1;

    // Aligned 8B access: one beat, no flags.
    dir_rdy = 1'b1;
    send(12'h000, 0, 1'b1, 3, 0);
    at_neg();
    chk("t1_vld", dir_vld, 1); chk("t1_cclass", dir_cclass, 0); chk("t1_second", dir_second, 0);
    chk("t1_flags", {dir_misalign, dir_line_cross, dir_page_cross}, 3'b000);
    at_neg();
    chk("t1_empty", dir_vld, 0);

    // Line-crossing split.
    send(12'h03C, 0, 1'b1, 3, 0);
    at_neg();
    chk("t2_b1_sum", dir_sum, 12'h03C); chk("t2_b1_cc", dir_cclass, 0);
    chk("t2_flags", {dir_misalign, dir_line_cross, dir_page_cross}, 3'b110);
    at_neg();
    chk("t2_b2_sum", dir_sum, 12'h040); chk("t2_b2_cc", dir_cclass, 1);
    chk("t2_b2_second", dir_second, 1); chk("t2_b2_lc", dir_line_cross, 1);
    at_neg();

    // Page-crossing split wraps to line 0.
    send(12'hFFC, 6'h3F, 1'b1, 3, 0);
    at_neg();
    chk("t3_b1_cc", dir_cclass, 6'h3F); chk("t3_pc", dir_page_cross, 1);
    at_neg();
    chk("t3_b2_sum", dir_sum, 0); chk("t3_b2_cc", dir_cclass, 0); chk("t3_b2_pc", dir_page_cross, 1);
    at_neg();

    // Forced index bit 57 on the second beat.
    send(12'h03C, 1, 1'b0, 3, 0);
    at_neg(); chk("t4_b1_cc", dir_cclass, 1);
    at_neg(); chk("t4_b2_cc", dir_cclass, 1);
    at_neg();
    send(12'h07C, 2, 1'b0, 3, 2);
    at_neg(); chk("t4b_b1_cc", dir_cclass, 2);
    at_neg(); chk("t4b_b2_cc", dir_cclass, 3); chk("t4b_b2_sum", dir_sum, 12'h080);
    at_neg();

    // Back-pressure: full queue holds the third request.
    dir_rdy = 1'b0;
    send(12'h100, 0, 1'b1, 0, 0);
    send(12'h200, 0, 1'b1, 0, 1);
    ex2_sum = 12'h300; ex2_sum_arr = 6'd3; ex2_tid = 2'd2; ex2_size = 3'd0; ex2_vld = 1'b1;
    at_neg(); chk("t5_full", ex2_rdy, 0); chk("t5_head", dir_sum, 12'h100);
    @(posedge clk); #2;
    at_neg(); chk("t5_held", ex2_rdy, 0);
    dir_rdy = 1'b1;
    at_neg(); chk("t5_rdy_back", ex2_rdy, 1); chk("t5_second", dir_sum, 12'h200);
    @(posedge clk); #2;
    ex2_vld = 1'b0;
    at_neg(); chk("t5_third", dir_sum, 12'h300); chk("t5_third_tid", dir_tid, 2);
    at_neg(); chk("t5_drained", dir_vld, 0);

    // Flush of a head stalled in its second beat.
    pulse_clr();
    dir_rdy = 1'b0;
    send(12'h03C, 0, 1'b1, 3, 1);
    send(12'h100, 4, 1'b1, 0, 0);
    dir_rdy = 1'b1;
    @(posedge clk); #2;
    dir_rdy = 1'b0;
    at_neg(); chk("t6_in_second", dir_second, 1); chk("t6_tid", dir_tid, 1);
    flush[1] = 1'b1;
    #1; chk("t6_masked", dir_vld, 0);
    @(posedge clk); #2;
    flush = '0;
    at_neg();
    chk("t6_next_vld", dir_vld, 1); chk("t6_next_sum", dir_sum, 12'h100);
    chk("t6_next_second", dir_second, 0); chk("t6_next_cc", dir_cclass, 4);
    chk("t6_perf0", perf_split_cnt, 0);
    dir_rdy = 1'b1;
    at_neg();
    for (int k = 0; k < 3; k++) begin
      send(12'h7FC, 5, 1'b1, 3, 0);
      at_neg(); at_neg();
    end
    at_neg();
`ifdef LQ_AGEN_LO_PERF_EN
    chk("t6_perf3", perf_split_cnt, 3);
`else
    chk("t6_perf_tied", perf_split_cnt, 0);
`endif
    pulse_clr();
    at_neg(); chk("t6_perf_clr", perf_split_cnt, 0);

    // Flush of a non-head entry compacts; flushed incoming request is dropped.
    dir_rdy = 1'b0;
    send(12'h100, 0, 1'b1, 0, 0);
    send(12'h200, 0, 1'b1, 0, 1);
    flush[1] = 1'b1;
    @(posedge clk); #2;
    flush = '0;
    at_neg(); chk("t7_compact_rdy", ex2_rdy, 1); chk("t7_head", dir_sum, 12'h100);
    flush[2] = 1'b1;
    send(12'h400, 0, 1'b1, 0, 2);
    flush = '0;
    at_neg(); chk("t7_dropped", ex2_rdy, 1);
    dir_rdy = 1'b1;
    at_neg(); chk("t7_empty", dir_vld, 0);

    // Reset in the middle of a split leaves no residual beat.
    send(12'h03C, 0, 1'b1, 3, 0);
    @(posedge clk); #2;
    dir_rdy = 1'b0;
    rst = 1'b1;
    #1;
    chk("t8_vld", dir_vld, 0); chk("t8_rdy", ex2_rdy, 1);
    chk("t8_second", dir_second, 0); chk("t8_sum", dir_sum, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    at_neg(); chk("t8_after", dir_vld, 0);
    dir_rdy = 1'b1;
    at_neg(); chk("t8_no_residual", dir_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lq_agen_lo_dirq.md
Name: lq_agen_lo_dirq

Overview:
- Downstream consumer of the low-order address-generation adder. Captures its 12-bit effective-address sum and 6-bit directory congruence-class index each cycle.
- Computes access-size alignment and crossing flags, then buffers requests in a small in-order queue.
- Issues L1 directory lookups over a valid/ready handshake. An access that crosses a 64B line becomes two directory beats: first line, then next line.

Parameters:
- QDEPTH, 2, queue entries (legal 2..4).
- PERF_W, 16, width of the split-access performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ex2_vld  in  1  request valid from the agen stage.
- ex2_rdy  out  1  queue can accept; depends only on registered state.
- ex2_sum  in  [0:11]  address bits 52:63, big-endian; bit 11 is the LSB.
- ex2_sum_arr  in  [0:5]  congruence-class index from the agen stage.
- ex2_dir_ig_57_b  in  1  active-low force of index bit 57 (cclass bit 5).
- ex2_size  in  [0:2]  encoded access size.
- ex2_tid  in  [0:1]  thread id.
- flush  in  [0:3]  per-thread flush, one-hot per bit.
- dir_vld  out  1  directory request valid.
- dir_rdy  in  1  directory accepts.
- dir_cclass  out  [0:5]  index for this beat.
- dir_sum  out  [0:11]  address for this beat.
- dir_tid  out  [0:1]  thread id of the head entry.
- dir_second  out  1  beat is the second half of a split access.
- dir_misalign  out  1  access is not naturally aligned.
- dir_line_cross  out  1  access crosses a 64B line.
- dir_page_cross  out  1  access crosses a 4KB page.
- perf_clr  in  1  synchronous clear of the perf counter.
- perf_split_cnt  out  [0:PERF_W-1]  count of completed split accesses.

Behaviour:
- Reset: queue empty; FSM=FIRST; ex2_rdy=1; dir_vld=0; all dir_* outputs=0; perf_split_cnt=0. Reset mid-split discards everything, with no residual beat.
- Size decode, bytes=2^ex2_size: 000=1, 001=2, 010=4, 011=8, 100=16, 101=32. Codes 110 and 111 decode as 1 byte.
- Flags are computed at enqueue and stored per entry:
  - misalign = (ex2_sum[6:11] & (bytes-1)) != 0.
  - line_cross = zero-extended ex2_sum[6:11] + bytes - 1 > 63.
  - page_cross = carry out of the 13-bit sum {0,ex2_sum} + bytes - 1.
  - page_cross implies line_cross.
- Enqueue occurs when ex2_vld & ex2_rdy & ~flush[ex2_tid]. A flushed incoming request is dropped.
- ex2_rdy = (count < QDEPTH), taken from registered count. There is no same-cycle pop bypass when full.
- Latency: a request enqueued at edge N drives dir_vld=1 after edge N, provided the queue was empty.
- dir_vld = head valid & ~flush[head.tid]. It is combinationally masked.
- FSM state FIRST:
  - dir_cclass = head.sum_arr; dir_sum = head.sum; dir_second=0.
  - On dir_vld & dir_rdy: if head.line_cross, go to SECOND with no pop. Otherwise pop.
- FSM state SECOND:
  - n = (head.sum[0:5] + 1) mod 64. Wrap 63->0 is required on page_cross.
  - dir_cclass = {n[0:4], n[5] | ~head.ig57_b}; dir_sum = {n, 000000}; dir_second=1.
  - On handshake: pop, return to FIRST.
- Flags are presented unchanged on both beats.
- Order is strictly FIFO. Pointers wrap modulo QDEPTH.
- Flush:
  - At the next edge, invalidate every entry whose tid has flush asserted, and compact the queue preserving order.
  - If the head is flushed, the FSM returns to FIRST.
  - Flush has priority over a same-cycle handshake; no pop credit is given for a flushed head.
- Simultaneous enqueue and pop update the count by net zero.
- dir_rdy without dir_vld has no effect. dir_* outputs hold while dir_vld=1 and dir_rdy=0.

Optional Feature:
- Macro LQ_AGEN_LO_PERF_EN.
- Defined:
  - perf_split_cnt increments on each SECOND-beat handshake.
  - It saturates at all-ones.
  - perf_clr clears it at the next edge, with priority over increment.
- Undefined: perf_split_cnt is tied to 0; perf_clr is ignored; no counter flops exist.

Test Plan:
- ex2_sum=0x000, size=011 (8B), dir_rdy=1 -> one beat next cycle: cclass=0, dir_second=0, all flags 0, queue empty after.
- ex2_sum=0x03C, size=011 -> misalign=1, line_cross=1, page_cross=0. Beat1: cclass=0, sum=0x03C. Beat2: cclass=1, sum=0x040, second=1. Two cycles with dir_rdy=1.
- ex2_sum=0xFFC, size=011, ex2_dir_ig_57_b=1 -> page_cross=1. Beat2 has cclass=0 and sum=0x000 (wrap).
- ex2_dir_ig_57_b=0, ex2_sum=0x03C, ex2_sum_arr=000001 -> beat1 cclass=000001, beat2 cclass=000001 (bit 5 forced).
- dir_rdy=0, three back-to-back ex2_vld with QDEPTH=2 -> ex2_rdy=0 after the 2nd accept, 3rd held. Raise dir_rdy -> three beats in order; ex2_rdy returns 1 the cycle after the first pop.
- Split on tid1 stalled in SECOND, assert flush[1] one cycle -> dir_vld=0 that cycle. Next cycle the tid0 entry behind it is presented with second=0. With the macro defined, perf_split_cnt=0 unchanged; after 3 completed splits it is 3, and perf_clr -> 0.
